// File: rtl/ram_rd_pkg.sv
// Shared types and sizing helpers for the RAM burst reader.
package ram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width needed to hold a FIFO occupancy of 0..depth inclusive.
  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous return-data FIFO; the head word is read straight from
// the storage registers so dout is valid whenever the FIFO is not empty.
module ram_rd_fifo
  import ram_rd_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = fifo_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok = pop & ~empty;
  assign empty  = (count == '0);
  assign dout   = mem[rd_ptr];

  // Storage, pointers and occupancy; reset flushes contents so no stale word survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read initiator for a 1-cycle registered-read RAM: issues sequential
// addresses under a credit limit and returns the data as a valid/ready stream.
module ram_burst_reader
  import ram_rd_pkg::*;
#(
  parameter int unsigned AW         = 8,
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  input  logic [DW-1:0] mem_q,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);

  localparam int unsigned CW = fifo_cnt_w(FIFO_DEPTH);
  localparam int unsigned SW = CW + 1;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_hold;
  logic [AW:0]   remaining;
  logic          inflight;
  logic          issue;
  logic          pop;
  logic          empty;
  logic [CW-1:0] count;
  logic [SW-1:0] used;

  assign mem_we  = 1'b0;
  assign m_valid = ~empty;
  assign pop     = m_valid & m_ready;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  // A read may be issued only if its word is guaranteed a FIFO slot when it lands.
  assign used  = SW'(count) + SW'(inflight) - SW'(pop);
  assign issue = (state == RUN) && (used < SW'(FIFO_DEPTH));

  // The live address is driven only while issuing; otherwise the last issued address is held.
  assign mem_addr = issue ? addr : addr_hold;

  ram_rd_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .din   (mem_q),
    .dout  (m_data),
    .count (count),
    .empty (empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue && (remaining == (AW+1)'(1))) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (empty && !inflight) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address/remaining counters, held address and the one-deep in-flight flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      addr_hold <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (state == IDLE && start) begin
        addr      <= base;
        remaining <= len;
      end else if (issue) begin
        addr      <= addr + AW'(1);
        remaining <= remaining - (AW+1)'(1);
        addr_hold <= addr;
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader with a behavioural registered-read RAM.
module tb_ram_burst_reader;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_q;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  always #5 clk = ~clk;

  ram_burst_reader #(
    .AW         (AW),
    .DW         (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base     (base),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_q    (mem_q),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  // Behavioural single-port RAM, 1-cycle registered read.
  logic [DW-1:0] ram [256];
  always @(posedge clk) mem_q <= ram[mem_addr];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard and monitor logs.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx[$];
  int            beat_cyc[$];
  int            rise_cyc[$];
  logic [AW-1:0] addr_log[$];
  int            cyc       = 0;
  int            done_cnt  = 0;
  int            busy_cnt  = 0;
  int            valid_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          valid_prev = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic          rand_ready = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (m_valid) valid_cnt++;
      if (m_valid && !valid_prev) rise_cyc.push_back(cyc);
      valid_prev = m_valid;
      if (mem_addr !== prev_addr) addr_log.push_back(mem_addr);
      prev_addr = mem_addr;
      check("mem_we_low", mem_we, 0);
      if (stall_prev) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, stall_data);
      end
      if (m_valid && m_ready) begin
        rx.push_back(m_data);
        beat_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_unexpected: got %0h expected none", m_data);
        end else begin
          check("beat_data", m_data, exp_q.pop_front());
        end
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
      if (done) begin
        done_cnt++;
        check("done_after_last_beat", exp_q.size(), 0);
      end
    end else begin
      stall_prev = 1'b0;
      valid_prev = 1'b0;
    end
  end

  // Drives start for one cycle and queues the reference words; returns the start cycle.
  task automatic start_burst(input logic [AW-1:0] b, input int l, output int scyc);
    @(posedge clk);
    #2;
    base  = b;
    len   = (AW+1)'(l);
    start = 1'b1;
    scyc  = cyc;
    for (int i = 0; i < l; i++) exp_q.push_back(ram[(int'(b) + i) % 256]);
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done) break;
    end
    if (n == 3000) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end
    @(negedge clk);
  endtask

  initial begin
    int sc, r0, d0, b0, v0, a0, n;
    logic [AW-1:0] rb;
    int rl;

    rst   = 1'b1;
    start = 1'b0;
    base  = '0;
    len   = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    ram[8'h01] = 8'h10;
    ram[8'h03] = 8'h30;
    ram[8'h06] = 8'h60;
    ram[8'h0a] = 8'ha0;
    ram[8'h0f] = 8'hf0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_we", mem_we, 0);
    #2 rst = 1'b0;

    // 1: full-rate burst from 00.
    rand_ready = 1'b0;
    r0 = rx.size(); d0 = done_cnt; n = rise_cyc.size();
    start_burst(8'h00, 16, sc);
    wait_done("t1");
    check("t1_beats", rx.size() - r0, 16);
    check("t1_latency", rise_cyc[n] - sc, 3);
    check("t1_no_bubbles", beat_cyc[r0 + 15] - beat_cyc[r0], 15);
    check("t1_beat1", rx[r0 + 1], 8'h10);
    check("t1_beat3", rx[r0 + 3], 8'h30);
    check("t1_beat15", rx[r0 + 15], 8'hf0);
    check("t1_done_once", done_cnt - d0, 1);

    // 2: same burst under random backpressure.
    rand_ready = 1'b1;
    r0 = rx.size(); d0 = done_cnt;
    start_burst(8'h00, 16, sc);
    wait_done("t2");
    check("t2_beats", rx.size() - r0, 16);
    check("t2_beat6", rx[r0 + 6], 8'h60);
    check("t2_done_once", done_cnt - d0, 1);

    // 3: address wrap.
    rand_ready = 1'b0;
    r0 = rx.size(); a0 = addr_log.size();
    start_burst(8'hfe, 4, sc);
    wait_done("t3");
    check("t3_beats", rx.size() - r0, 4);
    check("t3_naddr", addr_log.size() - a0, 4);
    if (addr_log.size() - a0 >= 4) begin
      check("t3_addr0", addr_log[a0], 8'hfe);
      check("t3_addr1", addr_log[a0 + 1], 8'hff);
      check("t3_addr2", addr_log[a0 + 2], 8'h00);
      check("t3_addr3", addr_log[a0 + 3], 8'h01);
    end

    // 4: zero-length burst.
    d0 = done_cnt; b0 = busy_cnt; v0 = valid_cnt; a0 = addr_log.size();
    start_burst(8'h40, 0, sc);
    wait_done("t4");
    check("t4_no_valid", valid_cnt - v0, 0);
    check("t4_no_addr", addr_log.size() - a0, 0);
    check("t4_busy_cycles", busy_cnt - b0, 1);
    check("t4_done_once", done_cnt - d0, 1);

    // 5: start while busy is ignored.
    rand_ready = 1'b1;
    r0 = rx.size(); d0 = done_cnt;
    start_burst(8'h20, 16, sc);
    repeat (3) @(posedge clk);
    #2 base = 8'h80; len = 9'd5; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done("t5");
    check("t5_beats", rx.size() - r0, 16);
    check("t5_done_once", done_cnt - d0, 1);

    // 6: reset mid-burst, then a clean single-word burst.
    rand_ready = 1'b0;
    r0 = rx.size();
    start_burst(8'h00, 16, sc);
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (rx.size() - r0 >= 5) break;
    end
    check("t6_reached_beat5", (rx.size() - r0 >= 5) ? 1 : 0, 1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_done", done, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    r0 = rx.size(); d0 = done_cnt;
    start_burst(8'h0a, 1, sc);
    wait_done("t6b");
    check("t6_beats", rx.size() - r0, 1);
    if (rx.size() > r0) check("t6_beat0", rx[r0], 8'ha0);
    check("t6_done_once", done_cnt - d0, 1);

    // Random bursts, including a full-memory sweep.
    rand_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rb = 8'($urandom);
      rl = (k == 4) ? 256 : int'($urandom_range(1, 40));
      r0 = rx.size();
      start_burst(rb, rl, sc);
      wait_done("rand");
      check("rand_beats", rx.size() - r0, rl);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
